// File: rtl/sequenciador_lote.sv
// Batch sequencer for the calculation unit's inicio/pronto handshake.
// Issues queued operand sets one at a time and collects each resultado into a readable table.
//
// state   | meaning
// OCIOSO  | idle after reset, waiting for iniciar
// EMITE   | load operands for slot idx, raise calc_inicio
// AGUARDA | calc_inicio held high, waiting for calc_pronto (timeout guarded)
// LIBERA  | calc_inicio low, waiting for calc_pronto to drop (timeout guarded)
// FIM     | batch done or aborted, waiting for iniciar
module sequenciador_lote #(
  parameter  int N_ENTRADAS = 4,
  parameter  int TIMEOUT    = 64,
  localparam int IW         = $clog2(N_ENTRADAS),
  localparam int NW         = IW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_addr_i,
  input  logic [15:0]   wr_A_i,
  input  logic [15:0]   wr_B_i,
  input  logic [15:0]   wr_C_i,
  input  logic [7:0]    wr_K_i,
  input  logic [NW-1:0] n_ops_i,
  input  logic          iniciar_i,
  output logic [15:0]   calc_A_o,
  output logic [15:0]   calc_B_o,
  output logic [15:0]   calc_C_o,
  output logic [7:0]    calc_K_o,
  output logic          calc_inicio_o,
  input  logic          calc_pronto_i,
  input  logic [15:0]   calc_resultado_i,
  input  logic [IW-1:0] rd_addr_i,
  output logic [15:0]   rd_resultado_o,
  output logic          ocupado_o,
  output logic          concluido_o,
  output logic          erro_timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ULTIMO = CW'(TIMEOUT - 1);
  localparam logic [NW-1:0] N_MAX      = NW'(N_ENTRADAS);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    EMITE   = 3'd1,
    AGUARDA = 3'd2,
    LIBERA  = 3'd3,
    FIM     = 3'd4
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] nops_q, nops_d;
  logic [15:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [7:0]    k_q, k_d;
  logic          inicio_q, inicio_d;
  logic          ocupado_q, ocupado_d;
  logic          concluido_q, concluido_d;
  logic          erro_q, erro_d;
  logic          res_we;
  logic          op_we;
  logic [NW-1:0] nops_sat;
  logic [15:0]   rd_q;

  logic [15:0] op_a_q [N_ENTRADAS];
  logic [15:0] op_b_q [N_ENTRADAS];
  logic [15:0] op_c_q [N_ENTRADAS];
  logic [7:0]  op_k_q [N_ENTRADAS];
  logic [15:0] res_q  [N_ENTRADAS];

  assign nops_sat = (n_ops_i > N_MAX) ? N_MAX : n_ops_i;

  always_comb begin
    estado_d    = estado_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    nops_d      = nops_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    k_d         = k_q;
    inicio_d    = inicio_q;
    ocupado_d   = ocupado_q;
    concluido_d = concluido_q;
    erro_d      = erro_q;
    res_we      = 1'b0;
    op_we       = 1'b0;
    case (estado_q)
      OCIOSO, FIM: begin
        op_we = wr_en_i;
        if (iniciar_i) begin
          nops_d = nops_sat;
          idx_d  = '0;
          erro_d = 1'b0;
          // An empty batch completes at once without touching the calculation unit.
          if (nops_sat == '0) begin
            estado_d    = FIM;
            ocupado_d   = 1'b0;
            concluido_d = 1'b1;
          end else begin
            estado_d    = EMITE;
            ocupado_d   = 1'b1;
            concluido_d = 1'b0;
          end
        end
      end
      EMITE: begin
        a_d      = op_a_q[idx_q];
        b_d      = op_b_q[idx_q];
        c_d      = op_c_q[idx_q];
        k_d      = op_k_q[idx_q];
        inicio_d = 1'b1;
        cnt_d    = '0;
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        if (calc_pronto_i) begin
          res_we   = 1'b1;
          inicio_d = 1'b0;
          cnt_d    = '0;
          estado_d = LIBERA;
        end else if (cnt_q == CNT_ULTIMO) begin
          inicio_d    = 1'b0;
          erro_d      = 1'b1;
          ocupado_d   = 1'b0;
          concluido_d = 1'b1;
          estado_d    = FIM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LIBERA: begin
        if (!calc_pronto_i) begin
          if (({1'b0, idx_q} + NW'(1)) == nops_q) begin
            ocupado_d   = 1'b0;
            concluido_d = 1'b1;
            estado_d    = FIM;
          end else begin
            idx_d    = idx_q + 1'b1;
            estado_d = EMITE;
          end
        end else if (cnt_q == CNT_ULTIMO) begin
          erro_d      = 1'b1;
          ocupado_d   = 1'b0;
          concluido_d = 1'b1;
          estado_d    = FIM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_q    <= OCIOSO;
      idx_q       <= '0;
      cnt_q       <= '0;
      nops_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      inicio_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      nops_q      <= nops_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      k_q         <= k_d;
      inicio_q    <= inicio_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
      erro_q      <= erro_d;
    end
  end

  // Operand table is deliberately left uninitialised by reset.
  always_ff @(posedge clk_i) begin
    if (op_we) begin
      op_a_q[wr_addr_i] <= wr_A_i;
      op_b_q[wr_addr_i] <= wr_B_i;
      op_c_q[wr_addr_i] <= wr_C_i;
      op_k_q[wr_addr_i] <= wr_K_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRADAS; i++) res_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (res_we) res_q[idx_q] <= calc_resultado_i;
      rd_q <= res_q[rd_addr_i];
    end
  end

  assign calc_A_o       = a_q;
  assign calc_B_o       = b_q;
  assign calc_C_o       = c_q;
  assign calc_K_o       = k_q;
  assign calc_inicio_o  = inicio_q;
  assign rd_resultado_o = rd_q;
  assign ocupado_o      = ocupado_q;
  assign concluido_o    = concluido_q;
  assign erro_timeout_o = erro_q;

endmodule

// File: tb/tb_sequenciador_lote.sv
// Directed bench for sequenciador_lote with a behavioural calculation unit (pronto after 3 cycles, result A+B+C+K).
module tb_sequenciador_lote;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_A = '0, wr_B = '0, wr_C = '0;
  logic [7:0]  wr_K = '0;
  logic [2:0]  n_ops = '0;
  logic        iniciar = 1'b0;
  logic [15:0] calc_A, calc_B, calc_C;
  logic [7:0]  calc_K;
  logic        calc_inicio;
  logic        calc_pronto = 1'b0;
  logic [15:0] calc_resultado;
  logic [1:0]  rd_addr = '0;
  logic [15:0] rd_resultado;
  logic        ocupado, concluido, erro_timeout;

  int tests = 0;
  int failed = 0;

  // Calculation unit model: 0 normal, 1 never ready, 2 pronto stuck high.
  int   mode = 0;
  int   mcnt = 0;
  int   pulses = 0;
  int   run_len = 0;
  int   last_len = 0;
  logic inicio_prev = 1'b0;
  logic [15:0] cap_A [16];
  logic [7:0]  cap_K [16];

  always #5 clk = ~clk;

  sequenciador_lote #(.N_ENTRADAS(4), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_A_i(wr_A), .wr_B_i(wr_B), .wr_C_i(wr_C), .wr_K_i(wr_K),
    .n_ops_i(n_ops), .iniciar_i(iniciar),
    .calc_A_o(calc_A), .calc_B_o(calc_B), .calc_C_o(calc_C), .calc_K_o(calc_K),
    .calc_inicio_o(calc_inicio), .calc_pronto_i(calc_pronto),
    .calc_resultado_i(calc_resultado),
    .rd_addr_i(rd_addr), .rd_resultado_o(rd_resultado),
    .ocupado_o(ocupado), .concluido_o(concluido), .erro_timeout_o(erro_timeout)
  );

  assign calc_resultado = calc_A + calc_B + calc_C + {8'd0, calc_K};

  always @(posedge clk) begin
    if (mode == 2) calc_pronto <= 1'b1;
    else if (mode == 1) calc_pronto <= 1'b0;
    else if (!calc_inicio) begin
      calc_pronto <= 1'b0;
      mcnt <= 0;
    end else begin
      if (mcnt < 3) mcnt <= mcnt + 1;
      if (mcnt == 2) calc_pronto <= 1'b1;
    end
  end

  always @(posedge clk) begin
    inicio_prev <= calc_inicio;
    if (calc_inicio && !inicio_prev) begin
      if (pulses < 16) begin
        cap_A[pulses] <= calc_A;
        cap_K[pulses] <= calc_K;
      end
      pulses <= pulses + 1;
    end
    if (calc_inicio) run_len <= run_len + 1;
    else begin
      if (inicio_prev) last_len <= run_len;
      run_len <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_slot(input logic [1:0] a, input logic [15:0] va, input logic [15:0] vb,
                            input logic [15:0] vc, input logic [7:0] vk);
    wr_en = 1'b1; wr_addr = a; wr_A = va; wr_B = vb; wr_C = vc; wr_K = vk;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start(input logic [2:0] n);
    n_ops = n; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!concluido && k < budget) begin
      tick();
      k++;
    end
    if (!concluido) check({tag, "_wait_concluido"}, 32'(concluido), 32'd1);
  endtask

  task automatic read_res(input logic [1:0] a, output logic [15:0] v);
    rd_addr = a;
    tick();
    v = rd_resultado;
  endtask

  initial begin
    logic [15:0] r;
    int base;
    int k;

    tick(); tick();
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_concluido", 32'(concluido), 32'd0);
    check("rst_erro", 32'(erro_timeout), 32'd0);
    check("rst_inicio", 32'(calc_inicio), 32'd0);
    check("rst_calcA", 32'(calc_A), 32'd0);
    rst = 1'b0;
    read_res(2'd0, r);
    check("rst_res0", 32'(r), 32'd0);

    write_slot(2'd0, 16'd3, 16'd4, 16'd6, 8'd8);
    write_slot(2'd1, 16'd1, 16'd1, 16'd1, 8'd1);
    write_slot(2'd2, 16'd100, 16'd200, 16'd300, 8'd0);
    write_slot(2'd3, 16'hFFFF, 16'd1, 16'd0, 8'd0);

    // single operation
    base = pulses;
    start(3'd1);
    check("single_ocupado", 32'(ocupado), 32'd1);
    wait_done("single", 50);
    check("single_pulses", 32'(pulses - base), 32'd1);
    check("single_A", 32'(cap_A[base]), 32'd3);
    check("single_K", 32'(cap_K[base]), 32'd8);
    check("single_ocupado_end", 32'(ocupado), 32'd0);
    check("single_erro", 32'(erro_timeout), 32'd0);
    read_res(2'd0, r);
    check("single_res0", 32'(r), 32'd21);

    // full batch of four
    base = pulses;
    start(3'd4);
    wait_done("batch", 100);
    check("batch_pulses", 32'(pulses - base), 32'd4);
    check("batch_A2", 32'(cap_A[base + 2]), 32'd100);
    check("batch_A3", 32'(cap_A[base + 3]), 32'hFFFF);
    check("batch_erro", 32'(erro_timeout), 32'd0);
    read_res(2'd0, r); check("batch_res0", 32'(r), 32'd21);
    read_res(2'd1, r); check("batch_res1", 32'(r), 32'd4);
    read_res(2'd2, r); check("batch_res2", 32'(r), 32'd600);
    read_res(2'd3, r); check("batch_res3", 32'(r), 32'h0000);

    // n_ops above table size saturates; iniciar and wr_en mid-batch are ignored
    write_slot(2'd3, 16'd5, 16'd5, 16'd5, 8'd5);
    base = pulses;
    start(3'd7);
    iniciar = 1'b1; wr_en = 1'b1; wr_addr = 2'd2;
    wr_A = 16'd9; wr_B = 16'd9; wr_C = 16'd9; wr_K = 8'd9;
    tick();
    iniciar = 1'b0; wr_en = 1'b0;
    wait_done("sat", 100);
    check("sat_pulses", 32'(pulses - base), 32'd4);
    read_res(2'd2, r); check("sat_res2_unwritten", 32'(r), 32'd600);
    read_res(2'd3, r); check("sat_res3", 32'(r), 32'd20);

    // calculation unit never answers
    mode = 1;
    base = pulses;
    start(3'd1);
    wait_done("tmo", 150);
    tick();
    check("tmo_pulses", 32'(pulses - base), 32'd1);
    check("tmo_inicio_len", 32'(last_len), 32'd64);
    check("tmo_erro", 32'(erro_timeout), 32'd1);
    check("tmo_concluido", 32'(concluido), 32'd1);
    check("tmo_inicio_low", 32'(calc_inicio), 32'd0);
    read_res(2'd0, r); check("tmo_res0_kept", 32'(r), 32'd21);

    // pronto stuck high: slot 0 captured, release phase times out
    write_slot(2'd0, 16'd1, 16'd2, 16'd3, 8'd4);
    mode = 2;
    tick();
    base = pulses;
    start(3'd2);
    check("stuck_erro_cleared", 32'(erro_timeout), 32'd0);
    wait_done("stuck", 150);
    check("stuck_pulses", 32'(pulses - base), 32'd1);
    check("stuck_erro", 32'(erro_timeout), 32'd1);
    read_res(2'd0, r); check("stuck_res0", 32'(r), 32'd10);
    read_res(2'd1, r); check("stuck_res1_kept", 32'(r), 32'd4);

    // reset during AGUARDA of slot 1
    mode = 0;
    tick(); tick();
    base = pulses;
    start(3'd4);
    k = 0;
    while (pulses < base + 2 && k < 50) begin
      tick();
      k++;
    end
    check("mid_reach_slot1", 32'(pulses - base), 32'd2);
    check("mid_inicio_before", 32'(calc_inicio), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_inicio_after", 32'(calc_inicio), 32'd0);
    check("mid_ocupado", 32'(ocupado), 32'd0);
    rst = 1'b0;
    read_res(2'd0, r); check("mid_res0", 32'(r), 32'd0);
    read_res(2'd1, r); check("mid_res1", 32'(r), 32'd0);
    read_res(2'd2, r); check("mid_res2", 32'(r), 32'd0);
    read_res(2'd3, r); check("mid_res3", 32'(r), 32'd0);

    // empty batch
    check("zero_concluido_before", 32'(concluido), 32'd0);
    base = pulses;
    start(3'd0);
    check("zero_concluido", 32'(concluido), 32'd1);
    check("zero_ocupado", 32'(ocupado), 32'd0);
    tick(); tick(); tick();
    check("zero_pulses", 32'(pulses - base), 32'd0);

    // normal batch after reset
    base = pulses;
    start(3'd4);
    wait_done("post", 100);
    check("post_pulses", 32'(pulses - base), 32'd4);
    read_res(2'd0, r); check("post_res0", 32'(r), 32'd10);
    read_res(2'd1, r); check("post_res1", 32'(r), 32'd4);
    read_res(2'd2, r); check("post_res2", 32'(r), 32'd600);
    read_res(2'd3, r); check("post_res3", 32'(r), 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
